// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants, the decode-stage state encoding and the buffered entry layout.
package riscv_pkg;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned OPC_W    = 7;
   localparam int unsigned REG_W    = 5;
   localparam int unsigned FUNCT3_W = 3;

   localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
   localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
   localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
   localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
   localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
   localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
   localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
   localparam logic [OPC_W-1:0] OPC_FENCE  = 7'b0001111;
   localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;

   // OP-IMM funct3 codes whose immediate is a 5-bit shift amount
   localparam logic [FUNCT3_W-1:0] F3_SLL     = 3'b001;
   localparam logic [FUNCT3_W-1:0] F3_SRL_SRA = 3'b101;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] imm;
      logic            illegal;
   } entry_t;

   function automatic logic is_supported(input logic [OPC_W-1:0] opc);
      logic ok;
      case (opc)
         OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
         OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_FENCE, OPC_SYSTEM: ok = 1'b1;
         default:                                             ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/immediate_generator.sv
// Combinational RV32I immediate extraction; unknown and immediate-free opcodes yield zero.
module immediate_generator
   import riscv_pkg::*;
(
   input  logic [31:0] instr,
   output logic [31:0] imm
);

   logic [OPC_W-1:0]    opcode;
   logic [FUNCT3_W-1:0] funct3;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];

   always_comb begin
      imm = '0;
      case (opcode)
         OPC_OP_IMM: begin
            if (funct3 == F3_SLL || funct3 == F3_SRL_SRA)
               imm = {27'b0, instr[24:20]};
            else
               imm = {{20{instr[31]}}, instr[31:20]};
         end
         OPC_LOAD, OPC_JALR: imm = {{20{instr[31]}}, instr[31:20]};
         OPC_STORE:          imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         OPC_BRANCH:         imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                                    instr[11:8], 1'b0};
         OPC_JAL:            imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                                    instr[30:21], 1'b0};
         OPC_LUI, OPC_AUIPC: imm = {instr[31:12], 12'b0};
         default:            imm = '0;
      endcase
   end

endmodule

// File: rtl/decode_stage.sv
// Decode stage with a two-entry skid buffer; ready depends only on registered state.
module decode_stage
   import riscv_pkg::*;
#(
   parameter bit ILLEGAL_CHECK = 1'b1
)(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_if_valid,
   output logic        o_if_ready,
   input  logic [31:0] i_if_instr,
   input  logic [31:0] i_if_pc,
   input  logic        i_flush,
   output logic        o_id_valid,
   input  logic        i_id_ready,
   output logic [31:0] o_id_pc,
   output logic [31:0] o_id_instr,
   output logic [31:0] o_id_imm,
   output logic [6:0]  o_id_opcode,
   output logic [4:0]  o_id_rd,
   output logic [4:0]  o_id_rs1,
   output logic [4:0]  o_id_rs2,
   output logic [2:0]  o_id_funct3,
   output logic        o_id_illegal
);

   state_t      state;
   state_t      state_next;
   logic        valid_q;
   logic        ready_q;
   logic        accept;
   logic        consume;
   logic        main_from_in;
   logic        main_from_skid;
   logic        skid_from_in;
   logic [31:0] in_imm;
   entry_t      in_entry;
   entry_t      main_q;
   entry_t      skid_q;

   immediate_generator u_immediate_generator (
      .instr (i_if_instr),
      .imm   (in_imm)
   );

   assign accept  = i_if_valid && ready_q;
   assign consume = valid_q && i_id_ready;

   always_comb begin
      in_entry.pc      = i_if_pc;
      in_entry.instr   = i_if_instr;
      in_entry.imm     = in_imm;
      in_entry.illegal = ILLEGAL_CHECK && !is_supported(i_if_instr[6:0]);
   end

   // State register; valid/ready flags are registered alongside the state
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state   <= ST_EMPTY;
         valid_q <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state   <= state_next;
         valid_q <= (state_next != ST_EMPTY);
         ready_q <= (state_next != ST_TWO);
      end
   end

   // Next-state logic; flush overrides any accept or consume
   always_comb begin
      state_next = state;
      if (i_flush) begin
         state_next = ST_EMPTY;
      end else begin
         case (state)
            ST_EMPTY: if (accept) state_next = ST_ONE;
            ST_ONE: begin
               if (accept && !consume)      state_next = ST_TWO;
               else if (consume && !accept) state_next = ST_EMPTY;
            end
            ST_TWO:   if (consume) state_next = ST_ONE;
            default:  state_next = ST_EMPTY;
         endcase
      end
   end

   // Buffer load controls; the skid entry only ever feeds the main entry, keeping order
   always_comb begin
      main_from_in   = 1'b0;
      main_from_skid = 1'b0;
      skid_from_in   = 1'b0;
      if (!i_flush) begin
         case (state)
            ST_EMPTY: main_from_in = accept;
            ST_ONE: begin
               main_from_in = accept && consume;
               skid_from_in = accept && !consume;
            end
            ST_TWO:   main_from_skid = consume;
            default: begin
               main_from_in   = 1'b0;
               main_from_skid = 1'b0;
               skid_from_in   = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (main_from_in)
            main_q <= in_entry;
         else if (main_from_skid)
            main_q <= skid_q;
         if (skid_from_in)
            skid_q <= in_entry;
      end
   end

   assign o_if_ready   = ready_q;
   assign o_id_valid   = valid_q;
   assign o_id_pc      = main_q.pc;
   assign o_id_instr   = main_q.instr;
   assign o_id_imm     = main_q.imm;
   assign o_id_opcode  = main_q.instr[6:0];
   assign o_id_rd      = main_q.instr[11:7];
   assign o_id_funct3  = main_q.instr[14:12];
   assign o_id_rs1     = main_q.instr[19:15];
   assign o_id_rs2     = main_q.instr[24:20];
   assign o_id_illegal = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: immediates, backpressure ordering, flush, reset and illegal flagging.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        flush;
   logic        id_ready;

   logic        if_ready,  id_valid,  id_illegal;
   logic [31:0] id_pc,     id_instr,  id_imm;
   logic [6:0]  id_opcode;
   logic [4:0]  id_rd,     id_rs1,    id_rs2;
   logic [2:0]  id_funct3;

   logic        n_if_ready, n_id_valid, n_id_illegal;
   logic [31:0] n_id_pc,    n_id_instr, n_id_imm;
   logic [6:0]  n_id_opcode;
   logic [4:0]  n_id_rd,    n_id_rs1,   n_id_rs2;
   logic [2:0]  n_id_funct3;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   decode_stage #(.ILLEGAL_CHECK(1'b1)) dut (
      .i_clk(clk), .i_rst(rst), .i_if_valid(if_valid), .o_if_ready(if_ready),
      .i_if_instr(if_instr), .i_if_pc(if_pc), .i_flush(flush),
      .o_id_valid(id_valid), .i_id_ready(id_ready),
      .o_id_pc(id_pc), .o_id_instr(id_instr), .o_id_imm(id_imm),
      .o_id_opcode(id_opcode), .o_id_rd(id_rd), .o_id_rs1(id_rs1), .o_id_rs2(id_rs2),
      .o_id_funct3(id_funct3), .o_id_illegal(id_illegal)
   );

   decode_stage #(.ILLEGAL_CHECK(1'b0)) dut_nochk (
      .i_clk(clk), .i_rst(rst), .i_if_valid(if_valid), .o_if_ready(n_if_ready),
      .i_if_instr(if_instr), .i_if_pc(if_pc), .i_flush(flush),
      .o_id_valid(n_id_valid), .i_id_ready(id_ready),
      .o_id_pc(n_id_pc), .o_id_instr(n_id_instr), .o_id_imm(n_id_imm),
      .o_id_opcode(n_id_opcode), .o_id_rd(n_id_rd), .o_id_rs1(n_id_rs1), .o_id_rs2(n_id_rs2),
      .o_id_funct3(n_id_funct3), .o_id_illegal(n_id_illegal)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one clock; outputs are then sampled 1 time unit after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr);
      if_valid = v;
      if_pc    = pc;
      if_instr = instr;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; id_ready = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      step();
      check("rst_valid",   32'(id_valid),   32'd0);
      check("rst_ready",   32'(if_ready),   32'd1);
      check("rst_pc",      id_pc,           32'h0);
      check("rst_instr",   id_instr,        32'h0);
      check("rst_imm",     id_imm,          32'h0);
      check("rst_rd",      32'(id_rd),      32'd0);
      check("rst_illegal", 32'(id_illegal), 32'd0);
      rst = 1'b0;

      // Streaming with execute always ready
      id_ready = 1'b1;
      drive(1'b1, 32'h100, 32'hFFF00093);            // addi x1,x0,-1
      step();
      check("addi_valid", 32'(id_valid),   32'd1);
      check("addi_imm",   id_imm,          32'hFFFFFFFF);
      check("addi_rd",    32'(id_rd),      32'd1);
      check("addi_pc",    id_pc,           32'h100);
      check("addi_opc",   32'(id_opcode),  32'h13);
      check("addi_ill",   32'(id_illegal), 32'd0);
      drive(1'b1, 32'h104, 32'h00309113);            // slli x2,x1,3
      step();
      check("slli_imm",   id_imm,          32'h3);
      check("slli_rs1",   32'(id_rs1),     32'd1);
      check("slli_rd",    32'(id_rd),      32'd2);
      check("slli_f3",    32'(id_funct3),  32'd1);
      drive(1'b1, 32'h108, 32'hFE000EE3);            // beq x0,x0,-4
      step();
      check("beq_imm",    id_imm,          32'hFFFFFFFC);
      check("beq_opc",    32'(id_opcode),  32'h63);
      check("beq_pc",     id_pc,           32'h108);
      drive(1'b0, 32'h0, 32'h0);
      step();
      check("drain_valid", 32'(id_valid), 32'd0);
      check("drain_ready", 32'(if_ready), 32'd1);

      // Backpressure: three instructions, execute stalled
      id_ready = 1'b0;
      drive(1'b1, 32'h200, 32'h00100093);            // addi x1,x0,1
      step();
      check("bp_a_pc",    id_pc,          32'h200);
      check("bp_a_ready", 32'(if_ready),  32'd1);
      drive(1'b1, 32'h204, 32'h00200113);            // addi x2,x0,2
      step();
      check("bp_two_ready", 32'(if_ready), 32'd0);
      check("bp_hold_pc",   id_pc,         32'h200);
      drive(1'b1, 32'h208, 32'h00300193);            // addi x3,x0,3
      step();
      check("bp_still_ready", 32'(if_ready), 32'd0);
      check("bp_stable_pc",   id_pc,         32'h200);
      check("bp_stable_imm",  id_imm,        32'h1);
      id_ready = 1'b1;
      step();
      check("bp_b_pc",    id_pc,          32'h204);
      check("bp_b_imm",   id_imm,         32'h2);
      check("bp_b_ready", 32'(if_ready),  32'd1);
      step();
      check("bp_c_pc",    id_pc,          32'h208);
      check("bp_c_rd",    32'(id_rd),     32'd3);
      check("bp_c_valid", 32'(id_valid),  32'd1);
      drive(1'b0, 32'h0, 32'h0);
      step();
      check("bp_end_valid", 32'(id_valid), 32'd0);

      // Flush while full with a same-cycle incoming instruction
      id_ready = 1'b0;
      drive(1'b1, 32'h300, 32'h00400213);
      step();
      drive(1'b1, 32'h304, 32'h00500293);
      step();
      check("fl_full_ready", 32'(if_ready), 32'd0);
      flush = 1'b1;
      drive(1'b1, 32'h308, 32'h00600313);
      step();
      check("fl_valid", 32'(id_valid), 32'd0);
      check("fl_ready", 32'(if_ready), 32'd1);
      flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      step();
      check("fl_no_ghost", 32'(id_valid), 32'd0);

      // Reset while full and execute ready
      drive(1'b1, 32'h400, 32'h00700393);
      step();
      drive(1'b1, 32'h404, 32'h00800413);
      step();
      check("rs_full_valid", 32'(id_valid), 32'd1);
      check("rs_full_ready", 32'(if_ready), 32'd0);
      rst = 1'b1; id_ready = 1'b1;
      drive(1'b1, 32'h408, 32'h00900493);
      step();
      check("rs_valid",   32'(id_valid),   32'd0);
      check("rs_ready",   32'(if_ready),   32'd1);
      check("rs_pc",      id_pc,           32'h0);
      check("rs_instr",   id_instr,        32'h0);
      check("rs_imm",     id_imm,          32'h0);
      check("rs_rs1",     32'(id_rs1),     32'd0);
      check("rs_illegal", 32'(id_illegal), 32'd0);
      rst = 1'b0;

      // Illegal opcode, then supported LUI and store
      drive(1'b1, 32'h500, 32'h0000007F);
      step();
      check("ill_valid",     32'(id_valid),     32'd1);
      check("ill_flag",      32'(id_illegal),   32'd1);
      check("ill_imm",       id_imm,            32'h0);
      check("ill_nochk_val", 32'(n_id_valid),   32'd1);
      check("ill_nochk",     32'(n_id_illegal), 32'd0);
      drive(1'b1, 32'h504, 32'h123450B7);            // lui x1,0x12345
      step();
      check("lui_imm", id_imm,          32'h12345000);
      check("lui_ill", 32'(id_illegal), 32'd0);
      drive(1'b1, 32'h508, 32'h0020A423);            // sw x2,8(x1)
      step();
      check("sw_imm", id_imm,      32'h8);
      check("sw_rs2", 32'(id_rs2), 32'd2);
      drive(1'b0, 32'h0, 32'h0);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter: ILLEGAL_CHECK, 1, when 1 flag unsupported opcodes on o_id_illegal; when 0 tie o_id_illegal to 0.
REQ-002 SHALL have port: i_clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: i_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: i_if_valid  input  1  fetch presents an instruction.
REQ-005 SHALL have port: o_if_ready  output  1  stage can accept an instruction this cycle.
REQ-006 SHALL have port: i_if_instr  input  32  instruction word.
REQ-007 SHALL have port: i_if_pc  input  32  instruction address.
REQ-008 SHALL have port: i_flush  input  1  discard all held and incoming instructions.
REQ-009 SHALL have port: o_id_valid  output  1  decoded instruction available.
REQ-010 SHALL have port: i_id_ready  input  1  execute consumes this cycle.
REQ-011 SHALL have ports: o_id_pc 32 and o_id_instr 32, both outputs, pass-through of the held entry.
REQ-012 SHALL have port: o_id_imm  output  32  decoded, sign- or zero-extended immediate.
REQ-013 SHALL have ports: o_id_opcode 7, o_id_rd 5, o_id_rs1 5, o_id_rs2 5, o_id_funct3 3, all outputs, instruction fields.
REQ-014 SHALL have port: o_id_illegal  output  1  held opcode unsupported.

Function
REQ-015 SHALL hold a two-entry buffer: main entry (drives o_id_*) and skid entry; each entry stores pc, instr and decoded imm.
REQ-016 SHALL run a state machine EMPTY (no entries), ONE (main only), TWO (main+skid).
REQ-017 SHALL drive o_if_ready = (state != TWO) from registered state only; no combinational path from i_id_ready.
REQ-018 SHALL drive o_id_valid = (state != EMPTY).
REQ-019 SHALL accept when i_if_valid && o_if_ready; SHALL consume when o_id_valid && i_id_ready.
REQ-020 SHALL transition: EMPTY+accept->ONE; ONE+accept+no consume->TWO; ONE+consume+no accept->EMPTY; ONE+accept+consume->ONE with new main; TWO+consume->ONE with skid moved to main; else hold.
REQ-021 SHALL preserve program order; an accepted instruction never overtakes an older one.
REQ-022 SHALL compute the immediate combinationally from i_if_instr at accept time and register it, giving 1-cycle latency from accept to o_id_valid.
REQ-023 SHALL decode immediates per RV32I: I-type (OP-IMM, LOAD, JALR) sign-extended imm[11:0]; OP-IMM funct3 001/101 zero-extended shamt = instr[24:20]; S, B, J sign-extended; LUI/AUIPC {instr[31:12],12'b0}; all other opcodes 0.
REQ-024 SHALL treat as supported opcodes: 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 0001111, 1110011; any other value sets o_id_illegal (ILLEGAL_CHECK=1).
REQ-025 SHALL on i_flush go to EMPTY next cycle, drop any same-cycle accept, and ignore same-cycle consume (flush wins over all).
REQ-026 SHALL hold o_id_* stable while o_id_valid && !i_id_ready.
REQ-027 SHALL zero the data fields of an entry when its valid clears is not required; only valid-qualified outputs are defined.

Reset
REQ-028 SHALL on i_rst go to EMPTY; o_id_valid=0, o_if_ready=1, o_id_pc/instr/imm=0, fields=0, o_id_illegal=0 the cycle after i_rst sampled high.
REQ-029 SHALL give i_rst priority over i_flush, accept and consume; reset mid-transfer discards both entries.

Structure
REQ-030 SHALL place opcode constants, funct3 shift codes and the state enum in shared package riscv_pkg.
REQ-031 SHALL instantiate immediate decoding as one sub-module, immediate_generator, fed from i_if_instr fields.

Verification
REQ-032 SHALL cover: addi x1,x0,-1 (0xFFF00093), i_id_ready=1 -> next cycle o_id_valid=1, o_id_imm=0xFFFFFFFF, o_id_rd=1.
REQ-033 SHALL cover: slli x2,x1,3 (0x00309113) -> o_id_imm=0x00000003, o_id_rs1=1; beq x0,x0,-4 (0xFE000EE3) -> o_id_imm=0xFFFFFFFC.
REQ-034 SHALL cover: three back-to-back instrs with i_id_ready=0 -> o_if_ready=0 after two accepts; release i_id_ready -> all three delivered in order, none lost or duplicated.
REQ-035 SHALL cover: state TWO with i_flush=1 and i_if_valid=1 -> next cycle o_id_valid=0, o_if_ready=1, incoming instr never appears.
REQ-036 SHALL cover: i_rst asserted in state TWO with i_id_ready=1 -> next cycle o_id_valid=0, all outputs 0.
REQ-037 SHALL cover: instr 0x0000007F -> o_id_illegal=1, o_id_imm=0; same with ILLEGAL_CHECK=0 -> o_id_illegal=0.
